// File: rtl/imm_field_packer.sv
// imm_field_packer
//   Narrows a 32-bit value into a 5-, 14- or 24-bit immediate field and flags
//   whether the value is representable, so that re-extending the packed field
//   with the same signop and field select reproduces the input exactly.
//   Two-stage valid/ready pipeline plus a saturating count of non-fitting
//   output beats.
//
// Optional build macro: IMM_PACK_SATURATE_EN
//   When defined, a non-fitting value is clamped to the nearest representable
//   field value instead of being truncated.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     input beat valid
//   in_ready     block can accept a beat (combinational from out_ready)
//   in_data      value to narrow
//   in_signop    1 = signed field, 0 = unsigned field
//   in_fsel      0 = 5 bits, 1 = 14 bits, 2/3 = 24 bits (3 flagged as bad)
//   out_valid    output beat valid
//   out_ready    downstream accepts the beat
//   out_field    packed field, zero above the field width
//   out_fit      value representable in the selected field
//   out_badsel   beat used the reserved field select 3
//   cnt_clr      clear the event counter (wins over a same-cycle increment)
//   fit_err_cnt  saturating count of transferred beats with out_fit = 0
module imm_field_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_signop,
  input  logic [1:0]       in_fsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_field,
  output logic             out_fit,
  output logic             out_badsel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] fit_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_data_q, s1_data_d;
  logic [4:0]  s1_w_q, s1_w_d;
  logic        s1_badsel_q, s1_badsel_d;
  logic        s1_fit_q, s1_fit_d;
`ifdef IMM_PACK_SATURATE_EN
  logic        s1_signop_q, s1_signop_d;
`endif

  // stage 2 state
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_field_q, s2_field_d;
  logic        s2_fit_q, s2_fit_d;
  logic        s2_badsel_q, s2_badsel_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // combinational helpers
  logic        s2_adv_s;
  logic        in_fire_s;
  logic        out_fire_s;
  logic [4:0]  w_s;
  logic        fit_s;
  logic [31:0] mask_s;
  logic [31:0] field_s;

  assign s2_adv_s   = ~s2_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_adv_s;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = s2_valid_q & out_ready;

  assign out_valid   = s2_valid_q;
  assign out_field   = s2_field_q;
  assign out_fit     = s2_fit_q;
  assign out_badsel  = s2_badsel_q;
  assign fit_err_cnt = cnt_q;

  // Width decode and fit check: a signed field fits when all bits from w-1
  // upward are copies of one value; unsigned fits when bits w and up are 0.
  always_comb begin
    w_s   = 5'd24;
    fit_s = 1'b0;
    case (in_fsel)
      2'd0: begin
        w_s   = 5'd5;
        fit_s = in_signop ? ((&in_data[31:4]) | ~(|in_data[31:4])) : ~(|in_data[31:5]);
      end
      2'd1: begin
        w_s   = 5'd14;
        fit_s = in_signop ? ((&in_data[31:13]) | ~(|in_data[31:13])) : ~(|in_data[31:14]);
      end
      default: begin
        w_s   = 5'd24;
        fit_s = in_signop ? ((&in_data[31:23]) | ~(|in_data[31:23])) : ~(|in_data[31:24]);
      end
    endcase
  end

  // Stage 1 next state: load when stage 2 can make room, capture data only on a valid beat.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_w_d      = s1_w_q;
    s1_badsel_d = s1_badsel_q;
    s1_fit_d    = s1_fit_q;
`ifdef IMM_PACK_SATURATE_EN
    s1_signop_d = s1_signop_q;
`endif
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d   = in_data;
        s1_w_d      = w_s;
        s1_badsel_d = (in_fsel == 2'd3);
        s1_fit_d    = fit_s;
`ifdef IMM_PACK_SATURATE_EN
        s1_signop_d = in_signop;
`endif
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Field packing: keep the low w bits; optionally clamp non-fitting values.
  always_comb begin
    mask_s  = (32'd1 << s1_w_q) - 32'd1;
    field_s = s1_data_q & mask_s;
`ifdef IMM_PACK_SATURATE_EN
    if (!s1_fit_q) begin
      if (s1_signop_q) begin
        // mask>>1 is the largest positive value; its complement within the field is the most negative.
        field_s = s1_data_q[31] ? (mask_s & ~(mask_s >> 1)) : (mask_s >> 1);
      end else begin
        field_s = mask_s;
      end
    end else begin
      field_s = s1_data_q & mask_s;
    end
`endif
  end

  // Stage 2 next state: advance whenever empty or the downstream accepts.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_field_d  = s2_field_q;
    s2_fit_d    = s2_fit_q;
    s2_badsel_d = s2_badsel_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_field_d  = field_s;
        s2_fit_d    = s1_fit_q;
        s2_badsel_d = s1_badsel_q;
      end else begin
        s2_field_d = s2_field_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Event counter: clear wins, otherwise count non-fitting transfers up to all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (out_fire_s && !s2_fit_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= 32'd0;
      s1_w_q      <= 5'd0;
      s1_badsel_q <= 1'b0;
      s1_fit_q    <= 1'b0;
`ifdef IMM_PACK_SATURATE_EN
      s1_signop_q <= 1'b0;
`endif
      s2_valid_q  <= 1'b0;
      s2_field_q  <= 32'd0;
      s2_fit_q    <= 1'b0;
      s2_badsel_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_w_q      <= s1_w_d;
      s1_badsel_q <= s1_badsel_d;
      s1_fit_q    <= s1_fit_d;
`ifdef IMM_PACK_SATURATE_EN
      s1_signop_q <= s1_signop_d;
`endif
      s2_valid_q  <= s2_valid_d;
      s2_field_q  <= s2_field_d;
      s2_fit_q    <= s2_fit_d;
      s2_badsel_q <= s2_badsel_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
